// File: rtl/audio_mixer.sv
// Mono PCM mixer: per-channel gain/mute, one shared multiplier stepping
// through the channels, saturating output register for the serializer.
module audio_mixer #(
  parameter int NUM_CH    = 4,
  parameter int IN_BITS   = 16,
  parameter int OUT_BITS  = 16,
  parameter int GAIN_BITS = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_tick,
  input  logic [NUM_CH*IN_BITS-1:0]     ch_in,
  input  logic [NUM_CH*GAIN_BITS-1:0]   ch_gain,
  input  logic [NUM_CH-1:0]             ch_mute,
  input  logic                          clr_flags,
  output logic [OUT_BITS-1:0]           pcm_out,
  output logic                          pcm_valid,
  output logic                          busy,
  output logic                          clip,
  output logic                          overrun
);

  localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ACC_W  = IN_BITS + GAIN_BITS + $clog2(NUM_CH) + 1;
  localparam int PROD_W = IN_BITS + GAIN_BITS + 1;
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-OUT_BITS+1){1'b0}}, {(OUT_BITS-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                        state_reg;
  logic [NUM_CH*IN_BITS-1:0]     in_shadow_reg;
  logic [NUM_CH*GAIN_BITS-1:0]   gain_shadow_reg;
  logic [NUM_CH-1:0]             mute_shadow_reg;
  logic [IDX_W-1:0]              idx_reg;
  logic signed [ACC_W-1:0]       acc_reg;

  logic signed [IN_BITS-1:0]     in_ch   [NUM_CH];
  logic [GAIN_BITS-1:0]          gain_ch [NUM_CH];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_unpack
      assign in_ch[gi]   = in_shadow_reg[gi*IN_BITS +: IN_BITS];
      assign gain_ch[gi] = gain_shadow_reg[gi*GAIN_BITS +: GAIN_BITS];
    end
  endgenerate

  logic signed [PROD_W-1:0] in_ext;
  logic signed [PROD_W-1:0] gain_ext;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  acc_next;

  // Gain is unsigned, so it is widened with a zero MSB before the signed multiply.
  always_comb begin
    in_ext   = PROD_W'(in_ch[idx_reg]);
    gain_ext = PROD_W'({1'b0, gain_ch[idx_reg]});
    prod     = mute_shadow_reg[idx_reg] ? '0 : in_ext * gain_ext;
    acc_next = acc_reg + ACC_W'(prod);
  end

  logic signed [ACC_W-1:0] shifted;
  logic [OUT_BITS-1:0]     sat_val;
  logic                    sat_hit;

  always_comb begin
    shifted = acc_reg >>> (GAIN_BITS-1);
    sat_hit = 1'b0;
    sat_val = shifted[OUT_BITS-1:0];
    if (shifted > SAT_MAX) begin
      sat_hit = 1'b1;
      sat_val = {1'b0, {(OUT_BITS-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      sat_hit = 1'b1;
      sat_val = {1'b1, {(OUT_BITS-1){1'b0}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      pcm_out         <= '0;
      pcm_valid       <= 1'b0;
      busy            <= 1'b0;
      clip            <= 1'b0;
      overrun         <= 1'b0;
      acc_reg         <= '0;
      idx_reg         <= '0;
      in_shadow_reg   <= '0;
      gain_shadow_reg <= '0;
      mute_shadow_reg <= '0;
    end else begin
      pcm_valid <= 1'b0;
      // Flag sets below are later in the block, so a set beats a clear.
      if (clr_flags) begin
        clip    <= 1'b0;
        overrun <= 1'b0;
      end
      case (state_reg)
        IDLE: begin
          if (sample_tick) begin
            in_shadow_reg   <= ch_in;
            gain_shadow_reg <= ch_gain;
            mute_shadow_reg <= ch_mute;
            acc_reg         <= '0;
            idx_reg         <= '0;
            busy            <= 1'b1;
            state_reg       <= MAC;
          end
        end
        MAC: begin
          if (sample_tick) overrun <= 1'b1;
          acc_reg <= acc_next;
          idx_reg <= idx_reg + IDX_W'(1);
          if (idx_reg == IDX_W'(NUM_CH-1)) state_reg <= OUT;
        end
        OUT: begin
          if (sample_tick) overrun <= 1'b1;
          if (sat_hit) clip <= 1'b1;
          pcm_out   <= sat_val;
          pcm_valid <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// Bench for audio_mixer: vector table plus random mixes through a scoreboard,
// and hand sequences for overrun, mid-mix input changes and mid-mix reset.
module tb_audio_mixer;

  localparam int NUM_CH    = 4;
  localparam int IN_BITS   = 16;
  localparam int OUT_BITS  = 16;
  localparam int GAIN_BITS = 8;
  localparam int LATENCY   = NUM_CH + 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        clr_flags;
  logic [63:0] ch_in;
  logic [31:0] ch_gain;
  logic [3:0]  ch_mute;
  logic [15:0] pcm_out;
  logic        pcm_valid;
  logic        busy;
  logic        clip;
  logic        overrun;

  audio_mixer #(
    .NUM_CH(NUM_CH), .IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .GAIN_BITS(GAIN_BITS)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick),
    .ch_in(ch_in), .ch_gain(ch_gain), .ch_mute(ch_mute),
    .clr_flags(clr_flags), .pcm_out(pcm_out), .pcm_valid(pcm_valid),
    .busy(busy), .clip(clip), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] ch;
    logic [31:0] gain;
    logic [3:0]  mute;
    logic [15:0] pcm;
    logic        clip;
  } vec_t;

  typedef struct {
    logic [15:0] pcm;
    logic        clip;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[12];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mix_no   = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Plain behavioural reference: full-precision sum, floor shift, clamp.
  function automatic void model(input logic [63:0] ch, input logic [31:0] g,
                                input logic [3:0] m, output logic [15:0] pcm,
                                output logic clp);
    longint sum = 0;
    longint r;
    for (int i = 0; i < 4; i++)
      if (!m[i]) sum += longint'($signed(ch[i*16 +: 16])) * longint'(g[i*8 +: 8]);
    r   = sum >>> 7;
    clp = 1'b0;
    if (r > 32767) begin
      r = 32767;
      clp = 1'b1;
    end else if (r < -32768) begin
      r = -32768;
      clp = 1'b1;
    end
    pcm = r[15:0];
  endfunction

  task automatic consume();
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_valid: got pcm_valid with pcm_out=0x%04h, expected no output", pcm_out);
    end else begin
      e = sb.pop_front();
      mix_no++;
      $display("mix %0d: pcm_out=0x%04h clip=%0b expected 0x%04h/%0b",
               mix_no, pcm_out, clip, e.pcm, e.clip);
      check("pcm_out", pcm_out, e.pcm);
      check("clip", clip, e.clip);
    end
  endtask

  task automatic run_mix(input vec_t v, input bit perturb);
    int lat;
    ch_in = v.ch; ch_gain = v.gain; ch_mute = v.mute;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    sb.push_back('{v.pcm, v.clip});
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("busy_start", busy, 1'b1);
    if (perturb) begin
      ch_in = {4{16'h7FFF}}; ch_gain = 32'hFFFFFFFF; ch_mute = 4'h0;
    end
    lat = 1;
    while (!pcm_valid && lat < 20) begin
      step();
      lat++;
    end
    if (!pcm_valid) begin
      n_checks++;
      n_fail++;
      $display("FAIL valid_timeout: got no pcm_valid in %0d cycles, expected one at %0d", lat, LATENCY);
      void'(sb.pop_front());
    end else begin
      check("latency", lat, LATENCY);
      check("busy_end", busy, 1'b0);
      consume();
      step();
      check("valid_pulse", pcm_valid, 1'b0);
      check("pcm_hold", pcm_out, v.pcm);
    end
  endtask

  initial begin
    vec_t v;
    int   nvalid;

    tbl[0]  = '{64'h0000_0000_0000_1234, 32'h80808080, 4'h0, 16'h1234, 1'b0};
    tbl[1]  = '{64'h7000_7000_7000_7000, 32'h80808080, 4'h0, 16'h7FFF, 1'b1};
    tbl[2]  = '{64'h9000_9000_9000_9000, 32'h80808080, 4'h0, 16'h8000, 1'b1};
    tbl[3]  = '{64'h0000_0000_0000_FFFD, 32'h80808040, 4'h0, 16'hFFFE, 1'b0};
    tbl[4]  = '{64'h0000_0000_1000_1000, 32'h808080FF, 4'h2, 16'h1FE0, 1'b0};
    tbl[5]  = '{64'h0000_0000_0000_7FFF, 32'h80808080, 4'h0, 16'h7FFF, 1'b0};
    tbl[6]  = '{64'h0000_0000_0000_8000, 32'h80808080, 4'h0, 16'h8000, 1'b0};
    tbl[7]  = '{64'h0000_0000_0000_7FFF, 32'h80808000, 4'h0, 16'h0000, 1'b0};
    tbl[8]  = '{64'h7000_7000_7000_7000, 32'h80808080, 4'hF, 16'h0000, 1'b0};
    tbl[9]  = '{64'h0001_0010_FF00_0100, 32'hFF408080, 4'h0, 16'h0009, 1'b0};
    tbl[10] = '{64'h8000_8000_8000_8000, 32'hFFFFFFFF, 4'h0, 16'h8000, 1'b1};
    tbl[11] = '{64'h7FFF_7FFF_7FFF_7FFF, 32'hFFFFFFFF, 4'h0, 16'h7FFF, 1'b1};

    reset = 1'b1; sample_tick = 1'b0; clr_flags = 1'b0;
    ch_in = '0; ch_gain = '0; ch_mute = '0;
    repeat (3) step();
    check("rst_pcm_out", pcm_out, 16'h0000);
    check("rst_pcm_valid", pcm_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_clip", clip, 1'b0);
    check("rst_overrun", overrun, 1'b0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 12; i++) run_mix(tbl[i], 1'b0);

    for (int i = 0; i < 6; i++) begin
      v.ch   = {$urandom(), $urandom()};
      v.gain = $urandom();
      v.mute = 4'($urandom_range(0, 15));
      if (i < 3) v.ch = v.ch & {4{16'h87FF}};
      model(v.ch, v.gain, v.mute, v.pcm, v.clip);
      run_mix(v, 1'b0);
    end

    // Inputs changed right after capture must not alter the result.
    run_mix(tbl[4], 1'b1);

    // Second tick three cycles into a mix: ignored, overrun flagged.
    ch_in = tbl[0].ch; ch_gain = tbl[0].gain; ch_mute = tbl[0].mute;
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("overrun_clear0", overrun, 1'b0);
    sb.push_back('{16'h1234, 1'b0});
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    step();
    ch_in = tbl[1].ch;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    check("overrun_set", overrun, 1'b1);
    nvalid = 0;
    for (int c = 0; c < 14; c++) begin
      if (pcm_valid) begin
        nvalid++;
        consume();
      end
      step();
    end
    check("overrun_nvalid", nvalid, 1);
    check("overrun_busy", busy, 1'b0);
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    check("overrun_cleared", overrun, 1'b0);

    // Reset two cycles into a mix aborts it silently.
    ch_in = tbl[1].ch; ch_gain = tbl[1].gain; ch_mute = tbl[1].mute;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_pcm_out", pcm_out, 16'h0000);
    nvalid = 0;
    for (int c = 0; c < 12; c++) begin
      if (pcm_valid) nvalid++;
      step();
    end
    check("abort_nvalid", nvalid, 0);
    check("abort_clip", clip, 1'b0);
    run_mix(tbl[0], 1'b0);

    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
